// File: rtl/unidad_logica_seq.sv
// Multi-cycle N-bit logic/arithmetic unit: processes SLICE bits per clock with a carry register between slices.
// Optional SUB (op 100) enabled by defining UNIDAD_LOGICA_SUB_EN.
module unidad_logica_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resultado,
  output logic             cout,
  output logic             cero
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
`ifdef UNIDAD_LOGICA_SUB_EN
  localparam logic [2:0] OP_SUB = 3'b100;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               cout_q, cout_d;
  logic               cero_q, cero_d;

  logic [SLICE-1:0]   a_sl, b_sl, b_eff, slice_res;
  logic [SLICE:0]     slice_sum;
  logic               is_arith, carry_nxt, seed;
  logic [WIDTH-1:0]   res_shift;

  // One slice of the datapath; operand registers are shifted so slice k is always at the LSBs.
  always_comb begin
    a_sl = a_q[SLICE-1:0];
    b_sl = b_q[SLICE-1:0];
`ifdef UNIDAD_LOGICA_SUB_EN
    b_eff    = (op_q == OP_SUB) ? ~b_sl : b_sl;
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
`else
    b_eff    = b_sl;
    is_arith = (op_q == OP_ADD);
`endif
    slice_sum = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
    carry_nxt = is_arith ? slice_sum[SLICE] : 1'b0;
    case (op_q)
      OP_AND:  slice_res = a_sl & b_sl;
      OP_OR:   slice_res = a_sl | b_sl;
      OP_XOR:  slice_res = a_sl ^ b_sl;
      OP_ADD:  slice_res = slice_sum[SLICE-1:0];
`ifdef UNIDAD_LOGICA_SUB_EN
      OP_SUB:  slice_res = slice_sum[SLICE-1:0];
`endif
      default: slice_res = '0;
    endcase
    // Result fills from the top so the LSB slice ends at bit 0 after N cycles.
    res_shift = (res_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
  end

`ifdef UNIDAD_LOGICA_SUB_EN
  assign seed = (op == OP_SUB);
`else
  assign seed = 1'b0;
`endif

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    cout_d  = cout_q;
    cero_d  = cero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_BUSY;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          carry_d = seed;
          res_d   = '0;
        end
      end
      S_BUSY: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        res_d   = res_shift;
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = S_DONE;
          cout_d  = carry_nxt;
          cero_d  = (res_shift == '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      cero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      cero_q  <= cero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign resultado = res_q;
  assign cout      = cout_q;
  assign cero      = cero_q;

endmodule
